// File: rtl/lcd_row_streamer.sv
// lcd_row_streamer: LCD-domain consumer of the download buffer.
// Reads buffered rows (1-cycle RAM) and streams pixels with SOF/EOL.
module lcd_row_streamer #(
    parameter int FRAME_WIDTH  = 480,
    parameter int FRAME_HEIGHT = 272,
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            cmd_data,
    input  logic                  cmd_available,
    output logic                  cmd_ack,
    output logic                  row_read_done,
    output logic [ADDR_WIDTH-1:0] buf_addr,
    input  logic [DATA_WIDTH-1:0] buf_data,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_sof,
    output logic                  pix_eol,
    output logic                  busy,
    output logic                  cmd_error
);
    localparam int RW = $clog2(FRAME_HEIGHT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [RW-1:0] ROWS = RW'(FRAME_HEIGHT);

    typedef enum logic [2:0] {
        IDLE,
        FRAME_START,
        WAIT_ROW,
        READ_ROW,
        DRAIN,
        ROW_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [RW-1:0]         row_cnt;
    logic [RW-1:0]         row_nxt;
    logic [ADDR_WIDTH-1:0] col;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  rd_pend;
    logic                  pend_sof;
    logic                  pend_eol;

    logic [DATA_WIDTH-1:0] f_data [2];
    logic [1:0]            f_sof;
    logic [1:0]            f_eol;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;

    logic       push;
    logic       pop;
    logic       issue;
    logic       cmd_bad;
    logic       credit_ok;
    logic       drain_done;
    logic [2:0] occ;

    assign push      = rd_pend;
    assign pix_valid = (count != 2'd0);
    assign pop       = pix_valid & pix_ready;
    assign row_nxt   = row_cnt + RW'(1);
    assign busy      = (state != IDLE);

    // Credits count reads in flight so the 2-entry FIFO can never overflow.
    assign occ        = {1'b0, count} + {2'b0, rd_pend} - {2'b0, pop};
    assign credit_ok  = (occ < 3'd2);
    assign drain_done = !rd_pend && ((count - {1'b0, pop}) == 2'd0);

    assign buf_addr = issue ? col : addr_q;
    assign pix_data = f_data[rd_ptr];
    assign pix_sof  = pix_valid & f_sof[rd_ptr];
    assign pix_eol  = pix_valid & f_eol[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cmd_available && cmd_data == 2'd1) begin
                    state_nxt = FRAME_START;
                end
            end
            FRAME_START: state_nxt = WAIT_ROW;
            WAIT_ROW: begin
                if (cmd_available && cmd_data == 2'd2) begin
                    state_nxt = READ_ROW;
                end else if (cmd_available && cmd_data == 2'd1) begin
                    state_nxt = FRAME_START;
                end
            end
            READ_ROW: begin
                if (issue && col == LAST_COL) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_nxt = ROW_DONE;
                end
            end
            ROW_DONE: begin
                state_nxt = (row_nxt == ROWS) ? IDLE : WAIT_ROW;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ack       = 1'b0;
        cmd_bad       = 1'b0;
        row_read_done = 1'b0;
        issue         = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ack = cmd_available;
                cmd_bad = cmd_available && (cmd_data != 2'd1);
            end
            WAIT_ROW: begin
                cmd_ack = cmd_available;
                cmd_bad = cmd_available && (cmd_data != 2'd2);
            end
            READ_ROW: issue = credit_ok;
            ROW_DONE: row_read_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_error <= 1'b0;
            row_cnt   <= '0;
            col       <= '0;
            addr_q    <= '0;
            rd_pend   <= 1'b0;
            pend_sof  <= 1'b0;
            pend_eol  <= 1'b0;
        end else begin
            if (cmd_bad) begin
                cmd_error <= 1'b1;
            end
            if (state == FRAME_START) begin
                row_cnt <= '0;
            end else if (state == ROW_DONE) begin
                row_cnt <= row_nxt;
            end
            if (state == WAIT_ROW && cmd_available && cmd_data == 2'd2) begin
                col <= '0;
            end else if (issue && col != LAST_COL) begin
                col <= col + ADDR_WIDTH'(1);
            end
            rd_pend <= issue;
            if (issue) begin
                addr_q   <= col;
                pend_sof <= (row_cnt == '0) && (col == '0);
                pend_eol <= (col == LAST_COL);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_data[0] <= '0;
            f_data[1] <= '0;
            f_sof     <= '0;
            f_eol     <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
        end else begin
            if (push) begin
                f_data[wr_ptr] <= buf_data;
                f_sof[wr_ptr]  <= pend_sof;
                f_eol[wr_ptr]  <= pend_eol;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // A push into a full FIFO without a pop would silently drop a pixel.
    assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && count == 2'd2) && count != 2'd3);

endmodule

// File: tb/tb_lcd_row_streamer.sv
// Testbench for lcd_row_streamer: command table, frame streaming,
// backpressure, frame restart and asynchronous reset mid-row.
module tb_lcd_row_streamer;
    localparam int W   = 480;
    localparam int H   = 4;
    localparam int AW  = 11;
    localparam int DW  = 16;
    localparam int TMO = 20000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    cmd_data = 2'd0;
    logic          cmd_available = 1'b0;
    logic          cmd_ack;
    logic          row_read_done;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_data = '0;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready = 1'b1;
    logic          pix_sof;
    logic          pix_eol;
    logic          busy;
    logic          cmd_error;

    lcd_row_streamer #(
        .FRAME_WIDTH (W),
        .FRAME_HEIGHT(H),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_data     (cmd_data),
        .cmd_available(cmd_available),
        .cmd_ack      (cmd_ack),
        .row_read_done(row_read_done),
        .buf_addr     (buf_addr),
        .buf_data     (buf_data),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_sof      (pix_sof),
        .pix_eol      (pix_eol),
        .busy         (busy),
        .cmd_error    (cmd_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sof;
        logic          eol;
    } pix_t;

    typedef struct {
        bit       rst;
        bit       av;
        bit [1:0] d;
        bit       ack;
        bit       bsy;
        bit       err;
        bit       vld;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int first_cyc = 0;
    bit first_pend = 0;
    int row_pix = 0;
    int npix = 0;
    int sof_cnt = 0;
    int eol_cnt = 0;
    int model_row = 0;
    int ram_row = 0;
    bit rnd_ready = 0;
    bit hold_v = 0;
    pix_t held;
    pix_t exp_q[$];
    logic [DW-1:0] ram [H][W];

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer RAM model: data for the address shown this cycle, next cycle.
    always @(posedge clk) buf_data <= ram[ram_row][buf_addr];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        pix_t e;
        if (row_read_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!reset_n) begin
            hold_v = 0;
        end else begin
            if (hold_v) begin
                check("stall_hold", {13'd0, pix_valid, pix_data, pix_sof, pix_eol},
                      {13'd0, 1'b1, held});
            end
            hold_v = pix_valid && !pix_ready;
            held   = '{pix_data, pix_sof, pix_eol};
            if (pix_valid && first_pend) begin
                first_cyc  = cyc;
                first_pend = 0;
            end
            if (pix_valid && pix_ready) begin
                row_pix++;
                npix++;
                sof_cnt += int'(pix_sof);
                eol_cnt += int'(pix_eol);
                if (exp_q.size() == 0) begin
                    check("pix_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("pix%0d", npix), {14'd0, pix_data, pix_sof, pix_eol},
                          {14'd0, e});
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            pix_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        cmd_available = 1'b0;
        cmd_data      = 2'd0;
        reset_n       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        model_row = 0;
    endtask

    task automatic fill_ram();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                ram[r][c] = DW'($urandom);
    endtask

    task automatic queue_row(input int r);
        for (int c = 0; c < W; c++)
            exp_q.push_back('{ram[r][c], (r == 0 && c == 0), (c == W - 1)});
    endtask

    task automatic send_cmd(input logic [1:0] c, input int hold, input int rr,
                            output int ack_cyc);
        int acks = 0;
        int n = 0;
        bit got = 0;
        ack_cyc = -1;
        @(posedge clk);
        #1;
        cmd_data      = c;
        cmd_available = 1'b1;
        while (!got && n < TMO) begin
            @(negedge clk);
            n++;
            if (cmd_ack) begin
                got = 1;
                acks++;
                ack_cyc = cyc;
                if (rr >= 0) begin
                    ram_row    = rr;
                    first_pend = 1;
                    row_pix    = 0;
                end
            end
        end
        check("ack_seen", 32'(got), 32'd1);
        if (got) begin
            for (int k = 1; k < hold; k++) begin
                @(negedge clk);
                if (cmd_ack) acks++;
            end
            check("ack_once", 32'(acks), 32'd1);
        end
        @(posedge clk);
        #1;
        cmd_available = 1'b0;
        cmd_data      = 2'd0;
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < TMO) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("row_done_seen", 32'(done_cnt > d0), 32'd1);
    endtask

    task automatic frame_start();
        int ta;
        fill_ram();
        model_row = 0;
        sof_cnt   = 0;
        eol_cnt   = 0;
        send_cmd(2'd1, 1, -1, ta);
    endtask

    task automatic run_row(input bit lat, input int hold);
        int r;
        int ta;
        int d0;
        r = model_row;
        queue_row(r);
        model_row++;
        d0 = done_cnt;
        send_cmd(2'd2, hold, r, ta);
        wait_done(d0);
        if (lat) begin
            check("lat_first", 32'(first_cyc - ta), 32'd3);
            check("lat_done", 32'(done_cyc - ta), 32'(W + 3));
        end
    endtask

    task automatic end_frame(input string tag, input int sofs);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_sof"}, 32'(sof_cnt), 32'(sofs));
        check({tag, "_eol"}, 32'(eol_cnt), 32'(H));
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vec_t tbl[12];
        int ta;
        int d0;
        int n;
        tbl[0]  = '{1, 0, 2'd0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 2'd2, 1, 0, 1, 0};
        tbl[2]  = '{0, 1, 2'd0, 1, 0, 1, 0};
        tbl[3]  = '{0, 1, 2'd1, 1, 1, 1, 0};
        tbl[4]  = '{1, 0, 2'd0, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 2'd1, 1, 1, 0, 0};
        tbl[6]  = '{0, 1, 2'd2, 0, 1, 0, 0};
        tbl[7]  = '{0, 0, 2'd0, 0, 1, 0, 0};
        tbl[8]  = '{0, 1, 2'd3, 1, 1, 1, 0};
        tbl[9]  = '{0, 0, 2'd0, 0, 1, 1, 0};
        tbl[10] = '{0, 1, 2'd0, 1, 1, 1, 0};
        tbl[11] = '{0, 0, 2'd0, 0, 1, 1, 0};

        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].rst) begin
                do_reset();
                @(posedge clk);
                #1;
            end
            cmd_available = tbl[i].av;
            cmd_data      = tbl[i].d;
            @(negedge clk);
            check($sformatf("tbl%0d_ack", i), 32'(cmd_ack), 32'(tbl[i].ack));
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
            check($sformatf("tbl%0d_err", i), 32'(cmd_error), 32'(tbl[i].err));
            check($sformatf("tbl%0d_vld", i), 32'(pix_valid), 32'(tbl[i].vld));
        end
        cmd_available = 1'b0;

        // Nominal frame, ready held high, first row-ready held 5 cycles.
        do_reset();
        frame_start();
        run_row(1, 5);
        for (int r = 1; r < H; r++) run_row(1, 1);
        end_frame("nominal", 1);
        check("nominal_err", 32'(cmd_error), 32'd0);

        // Backpressure; row 2 command raised while row 1 is still streaming.
        rnd_ready = 1;
        frame_start();
        run_row(0, 1);
        queue_row(1);
        model_row = 2;
        send_cmd(2'd2, 1, 1, ta);
        queue_row(2);
        model_row = 3;
        d0 = done_cnt;
        send_cmd(2'd2, 1, 2, ta);
        check("early_ack_after_done", 32'(done_cnt > d0), 32'd1);
        wait_done(d0 + 1);
        run_row(0, 1);
        end_frame("backpressure", 1);
        rnd_ready = 0;

        // Frame restart after row 1.
        do_reset();
        frame_start();
        run_row(0, 1);
        run_row(0, 1);
        check("restart_err_before", 32'(cmd_error), 32'd0);
        model_row = 0;
        send_cmd(2'd1, 1, -1, ta);
        check("restart_err", 32'(cmd_error), 32'd1);
        run_row(1, 1);
        run_row(1, 1);
        check("restart_rowcnt", 32'(busy), 32'd1);
        run_row(1, 1);
        run_row(1, 1);
        check("restart_busy", 32'(busy), 32'd0);
        check("restart_sof", 32'(sof_cnt), 32'd2);

        // Asynchronous reset during row 2.
        do_reset();
        frame_start();
        run_row(0, 1);
        run_row(0, 1);
        queue_row(2);
        model_row = 3;
        send_cmd(2'd2, 1, 2, ta);
        n = 0;
        while (row_pix < 200 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        check("midrow_reached", 32'(row_pix >= 200), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_ack", 32'(cmd_ack), 32'd0);
        check("rst_done", 32'(row_read_done), 32'd0);
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_sof", 32'(pix_sof), 32'd0);
        check("rst_eol", 32'(pix_eol), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(cmd_error), 32'd0);
        check("rst_addr", 32'(buf_addr), 32'd0);
        check("rst_data", 32'(pix_data), 32'd0);
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        check("rst_no_done", 32'(done_cnt), 32'(d0));
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        frame_start();
        for (int r = 0; r < H; r++) run_row(1, 1);
        end_frame("after_reset", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lcd_row_streamer.md
Name: lcd_row_streamer

Overview:
- Downstream consumer of the download buffer in the LCD clock domain.
- Accepts frame-start and row-ready commands from the buffer and acknowledges them.
- Reads each row out of the buffer's LCD-side RAM port (1-cycle read latency) and streams the pixels to the LCD timing controller over a valid/ready interface with SOF/EOL markers.
- Pulses row_read_done so the buffer can recycle the row.

Parameters:
FRAME_WIDTH, 480, pixels per row; must be ≥2 and ≤2**ADDR_WIDTH
FRAME_HEIGHT, 272, rows per frame; must be ≥1
ADDR_WIDTH, 11, buffer read address width
DATA_WIDTH, 16, pixel width (RGB565)

Ports:
clk  in  1  LCD pixel clock; the only clock
reset_n  in  1  asynchronous active-low reset
cmd_data  in  2  buffer command: 1 = frame start, 2 = row ready, 0/3 = illegal
cmd_available  in  1  command valid; held until cmd_ack seen
cmd_ack  out  1  one-cycle acknowledge pulse
row_read_done  out  1  one-cycle pulse: current row fully consumed
buf_addr  out  ADDR_WIDTH  buffer read address
buf_data  in  DATA_WIDTH  buffer read data, valid the cycle after buf_addr
pix_data  out  DATA_WIDTH  output pixel
pix_valid  out  1  pixel valid
pix_ready  in  1  downstream ready; transfer = pix_valid & pix_ready
pix_sof  out  1  qualifies the first pixel of a frame (row 0, col 0)
pix_eol  out  1  qualifies the last pixel of each row
busy  out  1  high in every state except IDLE
cmd_error  out  1  sticky illegal-command flag; cleared only by reset

Behaviour:
- Reset (async assert, sync release):
  - cmd_ack, row_read_done, pix_valid, pix_sof, pix_eol, busy, cmd_error = 0.
  - buf_addr, pix_data = 0; row/column counters = 0; output FIFO empty; state = IDLE.
- IDLE:
  - On cmd_available with cmd_data=1: cmd_ack=1 for one cycle, then FRAME_START.
  - Any other command: ack it (pulse), set cmd_error, stay in IDLE.
- FRAME_START (1 cycle): row_cnt←0, go to WAIT_ROW.
- WAIT_ROW:
  - On cmd_data=2: pulse cmd_ack, col←0, go to READ_ROW.
  - On cmd_data=1: pulse cmd_ack, set cmd_error, go to FRAME_START (frame restart).
  - On cmd_data=0/3: pulse cmd_ack, set cmd_error, stay.
  - No command is acked in any other state.
- READ_ROW (issues reads into a 2-entry output FIFO; credit-based backpressure):
  - Issue read at buf_addr=col only if (FIFO occupancy + reads in flight − pop this cycle) < 2, then col←col+1.
  - Read data is written to the FIFO the cycle after issue.
  - After issuing col=FRAME_WIDTH−1, go to DRAIN; no further issues.
  - buf_addr holds its last value when not issuing.
- DRAIN: wait until the FIFO is empty and no read is in flight, then ROW_DONE.
- ROW_DONE (1 cycle):
  - row_read_done=1, row_cnt←row_cnt+1.
  - If row_cnt+1 = FRAME_HEIGHT go to IDLE, else WAIT_ROW.
- Output side:
  - pix_valid = FIFO non-empty; pix_data/pix_sof/pix_eol come from the FIFO head.
  - Head must stay stable while pix_valid & !pix_ready.
  - sof/eol are computed at issue time and stored alongside each FIFO entry.
- Latency (pix_ready held 1):
  - READ_ROW entered at cycle T: addr 0 at T, pixel 0 valid at T+2.
  - One pixel per cycle thereafter; last pixel at T+FRAME_WIDTH+1; row_read_done at T+FRAME_WIDTH+2.
- Simultaneous push/pop in the same cycle is legal at any occupancy; the FIFO never overflows, and an overflow is a design error.
- Counters: col is ADDR_WIDTH bits and never exceeds FRAME_WIDTH−1; row_cnt is $clog2(FRAME_HEIGHT+1) bits.
- Reset mid-row: immediate return to reset values; no row_read_done is emitted.

Test Plan:
- Nominal: W=480, H=4, random RAM model with 1-cycle latency, pix_ready=1 → 4×480 pixels in order; pixel 0 at T+2; row_read_done 482 cycles after entering READ_ROW; exactly one sof; 4 eols at col 479; ends in IDLE with busy=0.
- Backpressure: random pix_ready at 30% duty → identical pixel sequence; no drop or duplicate; pix_data stable while stalled; FIFO occupancy never exceeds 2.
- Command protocol: cmd_available held 5 cycles → cmd_ack is exactly one pulse on acceptance; command 2 while in READ_ROW is not acked until WAIT_ROW.
- Illegal commands: cmd_data=2 in IDLE → acked, cmd_error=1, state stays IDLE; cmd_data=3 in WAIT_ROW → acked, error stays set, no pixels output.
- Frame restart: cmd_data=1 in WAIT_ROW after row 1 → cmd_error=1; next row streamed carries pix_sof on its first pixel; row_cnt restarts at 0.
- Async reset at pixel 200 of row 2 → all outputs 0 within the reset assertion without a clock edge; fresh frame-start after release streams correctly from row 0.
